oric_kbd_matrix: RTL and testbench

Converts host key events from the MiST user-I/O block into the 8×8 Oric Atmos keyboard matrix. The block sits between `user_io` and the `oricatmos` core. It keeps one pressed/released bit per matrix position, updated by `key_strobe` events. It answers the core's row/column scan with a registered key-sense bit. Build option: a minimum-hold stretcher, so that a short host press is still caught by the Oric firmware's 20 ms keyboard scan.

---
 rtl/oric_kbd_matrix.sv | 203 ++++++++++++++++++++
 tb/tb_oric_kbd_matrix.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oric_kbd_matrix.sv
// oric_kbd_matrix
//
// Converts host key events from the MiST user-I/O block into the 8x8 Oric
// Atmos keyboard matrix seen by the oricatmos core. One bit per matrix
// position records whether that key is down. The core scans the matrix with a
// row number and active-low column enables, and gets back a registered
// key-sense bit.
//
// Build option (macro ORIC_KBD_MIN_HOLD_EN): a minimum-hold stretcher. The
// most recently pressed key is kept down for at least HOLD_CYCLES clocks, so a
// very short host tap is still seen by the firmware's 20 ms keyboard scan.
// With the macro undefined there is no hold logic and HOLD_CYCLES is unused.
//
// Parameters
//   HOLD_CYCLES  minimum press length in clk_i cycles (1 .. 2^20-1)
// Ports
//   clk_i        system clock (24 MHz)
//   res_n_i      asynchronous active-low reset
//   key_strobe   one-cycle key event valid
//   key_pressed  1 = make, 0 = break (sampled with key_strobe)
//   key_extended E0-prefixed scan code (sampled with key_strobe)
//   key_code     PS/2 set-2 scan code (sampled with key_strobe)
//   row_sel      matrix row selected by the core
//   col_n        active-low column enables
//   key_sense    1 when any enabled column of the selected row is down
//   matrix_any   1 when any matrix bit is set
module oric_kbd_matrix #(
  parameter int unsigned HOLD_CYCLES = 480000
) (
  input  logic       clk_i,
  input  logic       res_n_i,
  input  logic       key_strobe,
  input  logic       key_pressed,
  input  logic       key_extended,
  input  logic [7:0] key_code,
  input  logic [2:0] row_sel,
  input  logic [7:0] col_n,
  output logic       key_sense,
  output logic       matrix_any
);

  // Matrix bit index is row*8 + col, which is why the decode table below
  // writes each position as a two-digit octal number (row digit, col digit).
  logic [63:0] mat;
  logic [63:0] mat_nxt;
  logic        dec_valid;
  logic [5:0]  dec_idx;
  logic        make_ev;
  logic        brk_ev;
  logic        brk_now;
  logic        clr_held;
  logic [5:0]  held_idx;

  // Scan code to matrix position, following the Atmos keyboard layout.
  always_comb begin
    dec_valid = 1'b1;
    dec_idx   = 6'o00;
    unique case ({key_extended, key_code})
      9'h03D: dec_idx = 6'o00; // 7
      9'h031: dec_idx = 6'o01; // N
      9'h02E: dec_idx = 6'o02; // 5
      9'h02A: dec_idx = 6'o03; // V
      9'h016: dec_idx = 6'o05; // 1
      9'h022: dec_idx = 6'o06; // X
      9'h026: dec_idx = 6'o07; // 3
      9'h03B: dec_idx = 6'o10; // J
      9'h02C: dec_idx = 6'o11; // T
      9'h02D: dec_idx = 6'o12; // R
      9'h02B: dec_idx = 6'o13; // F
      9'h076: dec_idx = 6'o15; // Esc
      9'h015: dec_idx = 6'o16; // Q
      9'h023: dec_idx = 6'o17; // D
      9'h03A: dec_idx = 6'o20; // M
      9'h036: dec_idx = 6'o21; // 6
      9'h032: dec_idx = 6'o22; // B
      9'h025: dec_idx = 6'o23; // 4
      9'h014: dec_idx = 6'o24; // Ctrl
      9'h01A: dec_idx = 6'o25; // Z
      9'h01E: dec_idx = 6'o26; // 2
      9'h021: dec_idx = 6'o27; // C
      9'h042: dec_idx = 6'o30; // K
      9'h046: dec_idx = 6'o31; // 9
      9'h04C: dec_idx = 6'o32; // ;
      9'h04E: dec_idx = 6'o33; // -
      9'h05D: dec_idx = 6'o36; // backslash
      9'h052: dec_idx = 6'o37; // '
      9'h029: dec_idx = 6'o40; // Space
      9'h041: dec_idx = 6'o41; // ,
      9'h049: dec_idx = 6'o42; // .
      9'h175: dec_idx = 6'o43; // Up
      9'h012: dec_idx = 6'o44; // LShift
      9'h16B: dec_idx = 6'o45; // Left
      9'h172: dec_idx = 6'o46; // Down
      9'h174: dec_idx = 6'o47; // Right
      9'h03C: dec_idx = 6'o50; // U
      9'h043: dec_idx = 6'o51; // I
      9'h044: dec_idx = 6'o52; // O
      9'h04D: dec_idx = 6'o53; // P
      9'h011: dec_idx = 6'o54; // Funct (Alt)
      9'h066: dec_idx = 6'o55; // Del (Backspace)
      9'h05B: dec_idx = 6'o56; // ]
      9'h054: dec_idx = 6'o57; // [
      9'h035: dec_idx = 6'o60; // Y
      9'h033: dec_idx = 6'o61; // H
      9'h034: dec_idx = 6'o62; // G
      9'h024: dec_idx = 6'o63; // E
      9'h01C: dec_idx = 6'o65; // A
      9'h01B: dec_idx = 6'o66; // S
      9'h01D: dec_idx = 6'o67; // W
      9'h03E: dec_idx = 6'o70; // 8
      9'h04B: dec_idx = 6'o71; // L
      9'h045: dec_idx = 6'o72; // 0
      9'h04A: dec_idx = 6'o73; // /
      9'h059: dec_idx = 6'o74; // RShift
      9'h05A: dec_idx = 6'o75; // Return
      9'h15A: dec_idx = 6'o75; // keypad Enter aliases Return
      9'h055: dec_idx = 6'o77; // =
      default: dec_valid = 1'b0;
    endcase
  end

  assign make_ev = key_strobe & key_pressed & dec_valid;
  assign brk_ev  = key_strobe & ~key_pressed & dec_valid;

`ifdef ORIC_KBD_MIN_HOLD_EN
  typedef enum logic [1:0] {IDLE, HOLD, HOLD_REL} hold_state_t;

  localparam logic [19:0] HOLD_LOAD = 20'(HOLD_CYCLES - 1);

  hold_state_t state;
  logic [19:0] hold_cnt;
  logic        hold_active;
  logic        hold_done;
  logic        brk_held;

  // hold_done marks the last cycle of the hold window: the counter steps
  // 1 -> 0 at this edge (or was loaded with 0), so a deferred release is
  // applied on the same edge.
  assign hold_active = (state != IDLE);
  assign hold_done   = hold_active && (hold_cnt <= 20'd1);
  assign brk_held    = brk_ev && hold_active && (dec_idx == held_idx);
  assign brk_now     = brk_ev && !brk_held;

  // The held key is dropped either when a different key takes over the hold
  // after its release was deferred, or when the window closes with the
  // release pending (including a release arriving in that final cycle).
  assign clr_held = make_ev ? ((state == HOLD_REL) && (dec_idx != held_idx))
                            : (hold_done && ((state == HOLD_REL) || brk_held));

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      state    <= IDLE;
      hold_cnt <= 20'd0;
      held_idx <= 6'd0;
    end else if (make_ev) begin
      state    <= HOLD;
      hold_cnt <= HOLD_LOAD;
      held_idx <= dec_idx;
    end else if (hold_done) begin
      state    <= IDLE;
      hold_cnt <= 20'd0;
    end else if (hold_active) begin
      hold_cnt <= hold_cnt - 20'd1;
      if (brk_held) begin
        state <= HOLD_REL;
      end
    end
  end
`else
  assign brk_now  = brk_ev;
  assign clr_held = 1'b0;
  assign held_idx = 6'd0;
`endif

  // Clears first, then the make, so a make always wins for its own key.
  always_comb begin
    mat_nxt = mat;
    if (clr_held) begin
      mat_nxt[held_idx] = 1'b0;
    end
    if (brk_now) begin
      mat_nxt[dec_idx] = 1'b0;
    end
    if (make_ev) begin
      mat_nxt[dec_idx] = 1'b1;
    end
  end

  // The scan outputs look at the matrix as it stands this cycle, so a key
  // event shows on key_sense one edge after it lands in mat.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      mat        <= 64'd0;
      key_sense  <= 1'b0;
      matrix_any <= 1'b0;
    end else begin
      mat        <= mat_nxt;
      key_sense  <= |(mat[{row_sel, 3'b000} +: 8] & ~col_n);
      matrix_any <= |mat;
    end
  end

endmodule

// File: tb/tb_oric_kbd_matrix.sv
// Testbench for oric_kbd_matrix, with HOLD_CYCLES = 100.
// Works for both builds; ORIC_KBD_MIN_HOLD_EN selects the expected behaviour.
module tb_oric_kbd_matrix;

  localparam int HOLD = 100;

  logic       clk_i = 1'b0;
  logic       res_n_i = 1'b0;
  logic       key_strobe = 1'b0;
  logic       key_pressed = 1'b0;
  logic       key_extended = 1'b0;
  logic [7:0] key_code = 8'h00;
  logic [2:0] row_sel = 3'd0;
  logic [7:0] col_n = 8'hFF;
  logic       key_sense;
  logic       matrix_any;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Model: one bit per key, plus the hold window as an absolute deadline.
  bit mdl_mat [64];
  bit exp_ks;
  bit exp_any;
`ifdef ORIC_KBD_MIN_HOLD_EN
  int held = -1;
  bit pend = 1'b0;
  int end_cyc = 0;
`endif

  // Keys with their matrix position as row*8+col; -1 marks unmapped codes.
  localparam int NK = 14;
  bit [8:0] k_code [NK] = '{9'h01C, 9'h029, 9'h05A, 9'h012, 9'h059, 9'h014,
                            9'h16B, 9'h174, 9'h15A, 9'h07E, 9'h06B, 9'h000,
                            9'h074, 9'h11C};
  int k_pos [NK] = '{6*8+5, 4*8+0, 7*8+5, 4*8+4, 7*8+4, 2*8+4,
                     4*8+5, 4*8+7, 7*8+5, -1, -1, -1, -1, -1};

  always #5 clk_i = ~clk_i;

  oric_kbd_matrix #(.HOLD_CYCLES(HOLD)) dut (
    .clk_i       (clk_i),
    .res_n_i     (res_n_i),
    .key_strobe  (key_strobe),
    .key_pressed (key_pressed),
    .key_extended(key_extended),
    .key_code    (key_code),
    .row_sel     (row_sel),
    .col_n       (col_n),
    .key_sense   (key_sense),
    .matrix_any  (matrix_any)
  );

  function automatic int lookup(input bit [8:0] code);
    int p = -1;
    for (int i = 0; i < NK; i++) begin
      if (k_code[i] == code) p = k_pos[i];
    end
    return p;
  endfunction

  task automatic mdl_clear();
    for (int i = 0; i < 64; i++) mdl_mat[i] = 1'b0;
`ifdef ORIC_KBD_MIN_HOLD_EN
    held = -1;
    pend = 1'b0;
`endif
  endtask

  // Applies one event in cycle cyc to the model.
  task automatic mdl_step(input bit strb, input bit pr, input bit [8:0] code);
    int k;
    k = strb ? lookup(code) : -1;
`ifdef ORIC_KBD_MIN_HOLD_EN
    if (k >= 0 && pr) begin
      if (held >= 0 && pend && held != k) mdl_mat[held] = 1'b0;
      mdl_mat[k] = 1'b1;
      held = k;
      pend = 1'b0;
      end_cyc = cyc + HOLD - 1;
    end else begin
      if (k >= 0) begin
        if (k == held) pend = 1'b1;
        else mdl_mat[k] = 1'b0;
      end
      if (held >= 0 && cyc == end_cyc) begin
        if (pend) mdl_mat[held] = 1'b0;
        held = -1;
        pend = 1'b0;
      end
    end
`else
    if (k >= 0) mdl_mat[k] = pr;
`endif
  endtask

  // Drives one cycle, computes the outputs expected after its closing edge.
  task automatic do_cycle(input bit strb, input bit pr, input bit [8:0] code,
                          input bit [2:0] row, input bit [7:0] cn);
    key_strobe   = strb;
    key_pressed  = pr;
    key_extended = code[8];
    key_code     = code[7:0];
    row_sel      = row;
    col_n        = cn;
    exp_ks  = 1'b0;
    exp_any = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (mdl_mat[row * 8 + c] && !cn[c]) exp_ks = 1'b1;
    end
    for (int i = 0; i < 64; i++) exp_any |= mdl_mat[i];
    mdl_step(strb, pr, code);
    @(posedge clk_i);
    #1;
    cyc++;
    key_strobe = 1'b0;
  endtask

  task automatic apply_reset();
    res_n_i = 1'b0;
    key_strobe = 1'b0;
    @(posedge clk_i);
    #1;
    @(posedge clk_i);
    #1;
    res_n_i = 1'b1;
    mdl_clear();
  endtask

  task automatic test_reset();
    apply_reset();
    tests++;
    if (key_sense !== 1'b0 || matrix_any !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_out: got ks=%b any=%b want 0 0", key_sense, matrix_any);
    end
    for (int r = 0; r < 8; r++) begin
      do_cycle(1'b0, 1'b0, 9'h000, 3'(r), 8'h00);
      tests++;
      if (key_sense !== 1'b0 || matrix_any !== 1'b0) begin
        fails++;
        $display("[TB] FAIL reset_scan row %0d: got ks=%b any=%b want 0 0", r, key_sense, matrix_any);
      end
    end
  endtask

  task automatic test_basic_make();
    apply_reset();
    do_cycle(1'b1, 1'b1, 9'h01C, 3'd6, 8'hDF);
    tests++;
    if (key_sense !== 1'b0) begin
      fails++;
      $display("[TB] FAIL make_a_edge1: got %b want 0", key_sense);
    end
    do_cycle(1'b0, 1'b0, 9'h000, 3'd6, 8'hDF);
    tests++;
    if (key_sense !== 1'b1 || matrix_any !== 1'b1) begin
      fails++;
      $display("[TB] FAIL make_a_edge2: got ks=%b any=%b want 1 1", key_sense, matrix_any);
    end
    do_cycle(1'b0, 1'b0, 9'h000, 3'd6, 8'hFF);
    tests++;
    if (key_sense !== 1'b0) begin
      fails++;
      $display("[TB] FAIL col_disable: got %b want 0", key_sense);
    end
  endtask

  task automatic test_back_to_back();
    bit [7:0] cols [3] = '{8'hEF, 8'hDF, 8'h7F};
    bit       want [3] = '{1'b1, 1'b1, 1'b0};
    apply_reset();
    do_cycle(1'b1, 1'b1, 9'h16B, 3'd0, 8'hFF);
    do_cycle(1'b1, 1'b1, 9'h012, 3'd0, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      do_cycle(1'b0, 1'b0, 9'h000, 3'd4, cols[i]);
      tests++;
      if (key_sense !== want[i] || matrix_any !== 1'b1) begin
        fails++;
        $display("[TB] FAIL b2b col_n=%h: got ks=%b any=%b want %b 1", cols[i], key_sense, matrix_any, want[i]);
      end
    end
  endtask

  task automatic test_unmapped();
    apply_reset();
    do_cycle(1'b1, 1'b0, 9'h07E, 3'd0, 8'hFF);
    do_cycle(1'b1, 1'b1, 9'h06B, 3'd0, 8'hFF);
    do_cycle(1'b1, 1'b1, 9'h074, 3'd0, 8'hFF);
    for (int r = 0; r < 8; r++) begin
      do_cycle(1'b0, 1'b0, 9'h000, 3'(r), 8'h00);
      tests++;
      if (key_sense !== 1'b0 || matrix_any !== 1'b0) begin
        fails++;
        $display("[TB] FAIL unmapped row %0d: got ks=%b any=%b want 0 0", r, key_sense, matrix_any);
      end
    end
  endtask

  // Make Space at k=0, break at k=10; key_sense after cycle k shows mat in k.
  task automatic test_hold_release();
    bit want;
    apply_reset();
    for (int k = 0; k <= 120; k++) begin
      do_cycle(k == 0 || k == 10, k == 0, 9'h029, 3'd4, 8'hFE);
`ifdef ORIC_KBD_MIN_HOLD_EN
      want = (k >= 1 && k <= 99);
`else
      want = (k >= 1 && k <= 10);
`endif
      tests++;
      if (key_sense !== want || key_sense !== exp_ks) begin
        fails++;
        $display("[TB] FAIL hold_release k=%0d: got %b want %b model %b", k, key_sense, want, exp_ks);
      end
    end
  endtask

  task automatic test_remake();
    bit want;
    bit strb;
    bit pr;
    apply_reset();
    for (int k = 0; k <= 320; k++) begin
      strb = (k == 0 || k == 10 || k == 50 || k == 200);
      pr   = (k == 0 || k == 50);
      do_cycle(strb, pr, 9'h029, 3'd4, 8'hFE);
`ifdef ORIC_KBD_MIN_HOLD_EN
      want = (k >= 1 && k <= 200);
`else
      want = (k >= 1 && k <= 10) || (k >= 51 && k <= 200);
`endif
      tests++;
      if (key_sense !== want || key_sense !== exp_ks) begin
        fails++;
        $display("[TB] FAIL remake k=%0d: got %b want %b model %b", k, key_sense, want, exp_ks);
      end
    end
  endtask

  task automatic test_random();
    int rate;
    bit strb;
    bit [8:0] code;
    bit [7:0] cn;
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      rate = ((i / 300) % 2 == 1) ? 64 : 4;
      strb = ($urandom_range(0, rate - 1) == 0);
      code = k_code[$urandom_range(0, NK - 1)];
      cn   = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      do_cycle(strb, 1'($urandom), code, 3'($urandom), cn);
      tests++;
      if (key_sense !== exp_ks || matrix_any !== exp_any) begin
        fails++;
        $display("[TB] FAIL random i=%0d: got ks=%b any=%b want %b %b", i, key_sense, matrix_any, exp_ks, exp_any);
      end
    end
  endtask

  task automatic test_async_reset();
    bit [8:0] keys [5] = '{9'h01C, 9'h029, 9'h05A, 9'h012, 9'h059};
    apply_reset();
    for (int i = 0; i < 5; i++) do_cycle(1'b1, 1'b1, keys[i], 3'd0, 8'hFF);
    do_cycle(1'b1, 1'b0, 9'h059, 3'd0, 8'hFF);
    do_cycle(1'b0, 1'b0, 9'h000, 3'd7, 8'h00);
    tests++;
    if (key_sense !== 1'b1 || matrix_any !== 1'b1) begin
      fails++;
      $display("[TB] FAIL pre_reset: got ks=%b any=%b want 1 1", key_sense, matrix_any);
    end
    #2;
    res_n_i = 1'b0;
    #1;
    tests++;
    if (key_sense !== 1'b0 || matrix_any !== 1'b0) begin
      fails++;
      $display("[TB] FAIL async_reset: got ks=%b any=%b want 0 0", key_sense, matrix_any);
    end
    @(posedge clk_i);
    #1;
    res_n_i = 1'b1;
    mdl_clear();
    for (int k = 0; k < 150; k++) begin
      do_cycle(1'b0, 1'b0, 9'h000, 3'(k % 8), 8'h00);
      tests++;
      if (key_sense !== 1'b0 || matrix_any !== 1'b0) begin
        fails++;
        $display("[TB] FAIL post_reset k=%0d: got ks=%b any=%b want 0 0", k, key_sense, matrix_any);
      end
    end
    do_cycle(1'b1, 1'b1, 9'h01C, 3'd6, 8'hDF);
    do_cycle(1'b0, 1'b0, 9'h000, 3'd6, 8'hDF);
    tests++;
    if (key_sense !== 1'b1 || matrix_any !== 1'b1) begin
      fails++;
      $display("[TB] FAIL new_make: got ks=%b any=%b want 1 1", key_sense, matrix_any);
    end
  endtask

  initial begin
    test_reset();
    test_basic_make();
    test_back_to_back();
    test_unmapped();
    test_hold_release();
    test_remake();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
